power_sequencer: RTL and testbench

Rail-ordering controller for the PMIC. It enables five supply rails in order 0→4 on power-up and disables them in order 4→0 on power-down. For each stage it issues a load to the downstream stage timer and waits for that timer's one-hot done pulse before moving on. It sits directly upstream of the stage timer: it drives the timer's load and one-hot select, and consumes its done vector. It also supervises for timeouts, unexpected done codes and, optionally, power-good failures.

---
 rtl/power_sequencer.sv | 160 ++++++++++++++++
 tb/tb_power_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// power_sequencer: orders five supply rails up (0..4) and down (4..0) through a stage timer.
// Define SEQ_PGOOD_CHECK_EN to add power-good supervision (fault code 2).
module power_sequencer #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwr_up_req,
  input  logic       pwr_dn_req,
  input  logic       clear_fault,
  input  logic [4:0] pgood,
  input  logic [4:0] tmr_done,
  output logic       tmr_ld,
  output logic [4:0] tmr_sel,
  output logic [4:0] rail_en,
  output logic       pwr_ok,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] stage
);

  typedef enum logic [2:0] {
    OFF, UP_START, UP_WAIT, ON, DN_START, DN_WAIT, FAULT
  } state_t;

  localparam logic [7:0] WDOG_LAST  = 8'(WDOG_CYCLES - 1);
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_PGOOD   = 2'd2;
  localparam logic [1:0] FC_CODE    = 2'd3;

  state_t     state, state_n;
  logic [2:0] stage_n;
  logic [4:0] rail_en_n, tmr_sel_n, stage_code;
  logic       tmr_ld_n;
  logic [1:0] fault_code_n;
  logic [7:0] wdog, wdog_n;
  logic       done_hit, pgood_bad_up, pgood_bad_on;

  assign stage_code = 5'b00001 << stage;
  assign done_hit   = (tmr_done == tmr_sel);

`ifdef SEQ_PGOOD_CHECK_EN
  assign pgood_bad_up = ((pgood & stage_code) == '0);
  assign pgood_bad_on = !(&pgood);
`else
  logic unused_pgood;
  assign unused_pgood = ^pgood;
  assign pgood_bad_up = 1'b0;
  assign pgood_bad_on = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    stage_n      = stage;
    rail_en_n    = rail_en;
    tmr_ld_n     = 1'b0;
    tmr_sel_n    = tmr_sel;
    fault_code_n = fault_code;
    wdog_n       = wdog;
    case (state)
      OFF:
        if (pwr_up_req && !pwr_dn_req) begin
          state_n = UP_START;
          stage_n = '0;
        end
      UP_START: begin
        rail_en_n = rail_en | stage_code;
        tmr_ld_n  = 1'b1;
        tmr_sel_n = stage_code;
        wdog_n    = '0;
        state_n   = UP_WAIT;
      end
      UP_WAIT, DN_WAIT:
        // tmr_sel is nonzero while waiting, so done_hit implies a real pulse
        if (done_hit) begin
          if (state == UP_WAIT) begin
            if (pgood_bad_up) begin
              state_n      = FAULT;
              fault_code_n = FC_PGOOD;
            end else if (pwr_dn_req) begin
              state_n = DN_START;
            end else if (stage == 3'd4) begin
              state_n   = ON;
              tmr_sel_n = '0;
            end else begin
              stage_n = stage + 3'd1;
              state_n = UP_START;
            end
          end else if (stage == '0) begin
            state_n   = OFF;
            tmr_sel_n = '0;
          end else begin
            stage_n = stage - 3'd1;
            state_n = DN_START;
          end
        end else if (tmr_done != '0) begin
          state_n      = FAULT;
          fault_code_n = FC_CODE;
        end else if (wdog == WDOG_LAST) begin
          state_n      = FAULT;
          fault_code_n = FC_TIMEOUT;
        end else begin
          wdog_n = wdog + 8'd1;
        end
      ON:
        if (pgood_bad_on) begin
          state_n      = FAULT;
          fault_code_n = FC_PGOOD;
        end else if (pwr_dn_req) begin
          state_n = DN_START;
          stage_n = 3'd4;
        end
      DN_START: begin
        rail_en_n = rail_en & ~stage_code;
        tmr_ld_n  = 1'b1;
        tmr_sel_n = stage_code;
        wdog_n    = '0;
        state_n   = DN_WAIT;
      end
      FAULT:
        if (clear_fault && !pwr_up_req) begin
          state_n      = OFF;
          fault_code_n = FC_NONE;
          stage_n      = '0;
        end
      default: state_n = OFF;
    endcase
    if (state_n == FAULT) begin
      rail_en_n = '0;
      tmr_sel_n = '0;
      tmr_ld_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OFF;
      stage      <= '0;
      rail_en    <= '0;
      tmr_ld     <= 1'b0;
      tmr_sel    <= '0;
      pwr_ok     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      wdog       <= '0;
    end else begin
      state      <= state_n;
      stage      <= stage_n;
      rail_en    <= rail_en_n;
      tmr_ld     <= tmr_ld_n;
      tmr_sel    <= tmr_sel_n;
      pwr_ok     <= (state_n == ON);
      fault      <= (state_n == FAULT);
      fault_code <= fault_code_n;
      wdog       <= wdog_n;
    end
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with a behavioural stage-timer model (delays 5,6,5,3,3).
// pgood scenarios run only when SEQ_PGOOD_CHECK_EN is defined.
module tb_power_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwr_up_req = 1'b0;
  logic       pwr_dn_req = 1'b0;
  logic       clear_fault = 1'b0;
  logic [4:0] pgood, tmr_done, tmr_sel, rail_en;
  logic       tmr_ld, pwr_ok, fault;
  logic [1:0] fault_code;
  logic [2:0] stage;

  logic [4:0] pg_mask = '0;
  logic [4:0] inject = '0;
  logic       tm_suppress = 1'b0;
  logic [4:0] model_done, tm_sel;
  logic       tm_busy;
  logic [3:0] tm_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ok_cycles = 0;

  power_sequencer #(.WDOG_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .pwr_up_req(pwr_up_req), .pwr_dn_req(pwr_dn_req),
    .clear_fault(clear_fault), .pgood(pgood), .tmr_done(tmr_done), .tmr_ld(tmr_ld),
    .tmr_sel(tmr_sel), .rail_en(rail_en), .pwr_ok(pwr_ok), .fault(fault),
    .fault_code(fault_code), .stage(stage)
  );

  always #5 clk = ~clk;

  assign pgood    = rail_en & ~pg_mask;
  assign tmr_done = model_done | inject;

  function automatic logic [3:0] stage_delay(input logic [4:0] sel);
    case (sel)
      5'b00001: return 4'd5;
      5'b00010: return 4'd6;
      5'b00100: return 4'd5;
      default:  return 4'd3;
    endcase
  endfunction

  // Stage timer: done pulse equal to the loaded select, delay cycles after the load is seen
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_done <= '0;
      tm_busy    <= 1'b0;
      tm_cnt     <= '0;
      tm_sel     <= '0;
    end else begin
      model_done <= '0;
      if (tmr_ld) begin
        tm_busy <= 1'b1;
        tm_cnt  <= stage_delay(tmr_sel);
        tm_sel  <= tmr_sel;
      end else if (tm_busy) begin
        if (tm_cnt == 4'd1) begin
          tm_busy <= 1'b0;
          if (!tm_suppress) model_done <= tm_sel;
        end else begin
          tm_cnt <= tm_cnt - 4'd1;
        end
      end
    end
  end

  always @(negedge clk) if (pwr_ok) ok_cycles <= ok_cycles + 1;

  task automatic wait_ld(input int budget, output bit seen, output int gap);
    seen = 1'b0;
    gap  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gap >= 0) gap++;
      if (tmr_done != '0) gap = 0;
      if (tmr_ld) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // which: 0 = tmr_sel cleared, 1 = pwr_ok, 2 = fault
  task automatic wait_for(input int which, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && tmr_sel == '0) || (which == 1 && pwr_ok) || (which == 2 && fault)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_to_off;
    pwr_up_req  = 1'b0;
    pwr_dn_req  = 1'b0;
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    int lds;
    repeat (2) @(negedge clk);
    tests++;
    if (rail_en !== 5'b0 || tmr_sel !== 5'b0 || tmr_ld !== 1'b0 || stage !== 3'd0) begin
      $display("FAIL reset_datapath: rail_en=%b tmr_sel=%b tmr_ld=%b stage=%0d, expected all 0",
               rail_en, tmr_sel, tmr_ld, stage);
      fails++;
    end
    tests++;
    if (pwr_ok !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      $display("FAIL reset_status: pwr_ok=%b fault=%b fault_code=%0d, expected 0 0 0",
               pwr_ok, fault, fault_code);
      fails++;
    end
    reset = 1'b0;
    pwr_up_req = 1'b1;
    pwr_dn_req = 1'b1;
    lds = 0;
    repeat (8) begin
      @(negedge clk);
      if (tmr_ld) lds++;
    end
    tests++;
    if (lds != 0 || rail_en !== 5'b0) begin
      $display("FAIL off_dn_priority: loads=%0d rail_en=%b, expected 0 and 00000", lds, rail_en);
      fails++;
    end
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_power_up;
    bit seen;
    int gap;
    logic [4:0] exp_en, exp_sel;
    pwr_up_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (tmr_ld !== 1'b1) begin
      $display("FAIL up_latency: tmr_ld=%b after 2 edges, expected 1", tmr_ld);
      fails++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        seen = tmr_ld;
        gap  = 2;
      end else begin
        wait_ld(40, seen, gap);
      end
      exp_en  = 5'((32'd1 << (i + 1)) - 1);
      exp_sel = 5'(32'd1 << i);
      tests++;
      if (!seen || rail_en !== exp_en || tmr_sel !== exp_sel || stage !== 3'(i) || gap != 2 || pwr_ok !== 1'b0) begin
        $display("FAIL up_stage%0d: ld=%b rail_en=%b tmr_sel=%b stage=%0d gap=%0d pwr_ok=%b, expected ld=1 rail_en=%b tmr_sel=%b stage=%0d gap=2 pwr_ok=0",
                 i, seen, rail_en, tmr_sel, stage, gap, pwr_ok, exp_en, exp_sel, i);
        fails++;
      end
    end
    wait_for(1, 20, seen);
    tests++;
    if (!seen || rail_en !== 5'b11111 || tmr_sel !== 5'b0 || stage !== 3'd4 || fault !== 1'b0) begin
      $display("FAIL up_on: pwr_ok=%b rail_en=%b tmr_sel=%b stage=%0d fault=%b, expected 1 11111 00000 4 0",
               pwr_ok, rail_en, tmr_sel, stage, fault);
      fails++;
    end
  endtask

  task automatic test_power_down;
    bit seen;
    int gap;
    logic [4:0] exp_en, exp_sel;
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      wait_ld(40, seen, gap);
      exp_en  = 5'((32'd1 << i) - 1);
      exp_sel = 5'(32'd1 << i);
      tests++;
      if (!seen || rail_en !== exp_en || tmr_sel !== exp_sel || stage !== 3'(i) || pwr_ok !== 1'b0 ||
          (i < 4 && gap != 2)) begin
        $display("FAIL dn_stage%0d: ld=%b rail_en=%b tmr_sel=%b stage=%0d pwr_ok=%b gap=%0d, expected ld=1 rail_en=%b tmr_sel=%b stage=%0d pwr_ok=0 gap=2",
                 i, seen, rail_en, tmr_sel, stage, pwr_ok, gap, exp_en, exp_sel, i);
        fails++;
      end
    end
    wait_for(0, 20, seen);
    tests++;
    if (!seen || rail_en !== 5'b0 || pwr_ok !== 1'b0 || stage !== 3'd0 || fault !== 1'b0) begin
      $display("FAIL dn_off: sel_cleared=%b rail_en=%b pwr_ok=%b stage=%0d fault=%b, expected 1 00000 0 0 0",
               seen, rail_en, pwr_ok, stage, fault);
      fails++;
    end
    pwr_dn_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout;
    bit seen;
    int gap;
    pwr_up_req = 1'b1;
    for (int i = 0; i < 3; i++) wait_ld(40, seen, gap);
    tm_suppress = 1'b1;
    tests++;
    if (!seen || stage !== 3'd2) begin
      $display("FAIL to_reach_stage2: ld=%b stage=%0d, expected 1 2", seen, stage);
      fails++;
    end
    repeat (63) @(negedge clk);
    tests++;
    if (fault !== 1'b0 || rail_en !== 5'b00111) begin
      $display("FAIL to_early: fault=%b rail_en=%b after 63 wait cycles, expected 0 00111", fault, rail_en);
      fails++;
    end
    @(negedge clk);
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || rail_en !== 5'b0 || tmr_sel !== 5'b0 ||
        tmr_ld !== 1'b0 || pwr_ok !== 1'b0) begin
      $display("FAIL to_fault: fault=%b code=%0d rail_en=%b tmr_sel=%b tmr_ld=%b pwr_ok=%b, expected 1 1 00000 00000 0 0",
               fault, fault_code, rail_en, tmr_sel, tmr_ld, pwr_ok);
      fails++;
    end
    tm_suppress = 1'b0;
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'd1) begin
      $display("FAIL to_clear_blocked: fault=%b code=%0d with pwr_up_req=1, expected 1 1", fault, fault_code);
      fails++;
    end
    pwr_up_req  = 1'b0;
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    tests++;
    if (fault !== 1'b0 || fault_code !== 2'd0 || stage !== 3'd0 || rail_en !== 5'b0) begin
      $display("FAIL to_clear: fault=%b code=%0d stage=%0d rail_en=%b, expected 0 0 0 00000",
               fault, fault_code, stage, rail_en);
      fails++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrong_code;
    bit seen;
    int gap;
    pwr_up_req = 1'b1;
    wait_ld(40, seen, gap);
    wait_ld(40, seen, gap);
    inject = 5'b00100;
    @(negedge clk);
    inject = '0;
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'd3 || rail_en !== 5'b0 || tmr_sel !== 5'b0) begin
      $display("FAIL wc_fault: fault=%b code=%0d rail_en=%b tmr_sel=%b, expected 1 3 00000 00000",
               fault, fault_code, rail_en, tmr_sel);
      fails++;
    end
    repeat (10) @(negedge clk);
    tests++;
    if (fault !== 1'b1 || fault_code !== 2'd3 || rail_en !== 5'b0) begin
      $display("FAIL wc_latched: fault=%b code=%0d rail_en=%b, expected 1 3 00000", fault, fault_code, rail_en);
      fails++;
    end
    clear_to_off();
  endtask

  task automatic test_abort;
    bit seen;
    int gap;
    int unsigned ok_before;
    int lds;
    logic [4:0] exp_en, exp_sel;
    ok_before = ok_cycles;
    pwr_up_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_ld(40, seen, gap);
    pwr_dn_req = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      wait_ld(40, seen, gap);
      exp_en  = 5'((32'd1 << i) - 1);
      exp_sel = 5'(32'd1 << i);
      tests++;
      if (!seen || rail_en !== exp_en || tmr_sel !== exp_sel || stage !== 3'(i) || gap != 2) begin
        $display("FAIL abort_stage%0d: ld=%b rail_en=%b tmr_sel=%b stage=%0d gap=%0d, expected ld=1 rail_en=%b tmr_sel=%b stage=%0d gap=2",
                 i, seen, rail_en, tmr_sel, stage, gap, exp_en, exp_sel, i);
        fails++;
      end
    end
    wait_for(0, 20, seen);
    lds = 0;
    repeat (10) begin
      @(negedge clk);
      if (tmr_ld) lds++;
    end
    tests++;
    if (!seen || rail_en !== 5'b0 || lds != 0 || ok_cycles != ok_before) begin
      $display("FAIL abort_off: sel_cleared=%b rail_en=%b loads=%0d pwr_ok_cycles=%0d, expected 1 00000 0 0",
               seen, rail_en, lds, ok_cycles - ok_before);
      fails++;
    end
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bit seen;
    int gap;
    pwr_up_req = 1'b1;
    for (int i = 0; i < 3; i++) wait_ld(40, seen, gap);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (rail_en !== 5'b0 || tmr_ld !== 1'b0 || tmr_sel !== 5'b0 || stage !== 3'd0) begin
      $display("FAIL async_reset: rail_en=%b tmr_ld=%b tmr_sel=%b stage=%0d before next edge, expected 00000 0 00000 0",
               rail_en, tmr_ld, tmr_sel, stage);
      fails++;
    end
    pwr_up_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef SEQ_PGOOD_CHECK_EN
  task automatic test_pgood;
    bit seen;
    pg_mask = 5'b00001;
    pwr_up_req = 1'b1;
    wait_for(2, 40, seen);
    tests++;
    if (!seen || fault_code !== 2'd2 || rail_en !== 5'b0 || stage !== 3'd0) begin
      $display("FAIL pg_up: fault=%b code=%0d rail_en=%b stage=%0d, expected 1 2 00000 0",
               seen, fault_code, rail_en, stage);
      fails++;
    end
    pg_mask = '0;
    clear_to_off();
    pwr_up_req = 1'b1;
    wait_for(1, 100, seen);
    pg_mask = 5'b10000;
    @(negedge clk);
    tests++;
    if (!seen || fault !== 1'b1 || fault_code !== 2'd2 || rail_en !== 5'b0 || pwr_ok !== 1'b0) begin
      $display("FAIL pg_on: reached_on=%b fault=%b code=%0d rail_en=%b pwr_ok=%b, expected 1 1 2 00000 0",
               seen, fault, fault_code, rail_en, pwr_ok);
      fails++;
    end
    pg_mask = '0;
    clear_to_off();
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout();
    test_wrong_code();
    test_abort();
    test_async_reset();
`ifdef SEQ_PGOOD_CHECK_EN
    test_pgood();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
